// File: rtl/stream_gen_pkg.sv
// rtl/stream_gen_pkg.sv - shared encodings for the valid/ready stream generator
package stream_gen_pkg;

   localparam int PKT_CNT_W = 16;

   localparam logic [1:0] MODE_CONT = 2'd0;
   localparam logic [1:0] MODE_GAP  = 2'd1;
   localparam logic [1:0] MODE_PKT  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   // The reserved encoding behaves as continuous mode.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_CONT : m;
   endfunction

endpackage

// File: rtl/stream_master_gen.sv
// rtl/stream_master_gen.sv - incrementing valid/ready stream source with
// continuous, gapped and packet modes
module stream_master_gen
   import stream_gen_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PKT_LEN   = 16,
   parameter int GAP_CYC   = 0,
   parameter int START_VAL = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic                 ready,
   output logic [DATA_W-1:0]    data,
   output logic                 valid,
   output logic                 last,
   output logic [PKT_CNT_W-1:0] pkt_cnt
);

   localparam int BW = $clog2(PKT_LEN + 1);
   localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t                 state, state_nxt;
   logic [1:0]             mode_q, mode_nxt;
   logic [BW-1:0]          beat_q, beat_nxt;
   logic [GW-1:0]          gap_q, gap_nxt;
   logic [DATA_W-1:0]      data_nxt;
   logic                   valid_nxt, last_nxt;
   logic [PKT_CNT_W-1:0]   pkt_nxt;
   logic                   hs;

   assign hs = valid && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         mode_q  <= MODE_CONT;
         beat_q  <= '0;
         gap_q   <= '0;
         data    <= DATA_W'(START_VAL);
         valid   <= 1'b0;
         last    <= 1'b0;
         pkt_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         beat_q  <= beat_nxt;
         gap_q   <= gap_nxt;
         data    <= data_nxt;
         valid   <= valid_nxt;
         last    <= last_nxt;
         pkt_cnt <= pkt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      gap_nxt   = gap_q;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nxt = ST_SEND;
               mode_nxt  = norm_mode(mode);
            end
         end
         ST_SEND: begin
            // Dropping en wins over a pending gap.
            if (hs) begin
               if (!en) begin
                  state_nxt = ST_IDLE;
               end else if (GAP_CYC > 0 &&
                            (mode_q == MODE_GAP || (mode_q == MODE_PKT && last))) begin
                  state_nxt = ST_GAP;
                  gap_nxt   = '0;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (en) begin
                  state_nxt = ST_SEND;
                  mode_nxt  = norm_mode(mode);
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               gap_nxt = gap_q + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs are precomputed from the next state, so ready never
   // reaches an output combinationally.
   always_comb begin
      data_nxt  = hs ? data + 1'b1 : data;
      beat_nxt  = beat_q;
      pkt_nxt   = pkt_cnt;
      if (hs) begin
         beat_nxt = (beat_q == LAST_IDX) ? '0 : beat_q + 1'b1;
         if (last) begin
            pkt_nxt = pkt_cnt + 1'b1;
         end
      end
      valid_nxt = (state_nxt == ST_SEND);
      last_nxt  = (state_nxt == ST_SEND) && (mode_nxt == MODE_PKT) && (beat_nxt == LAST_IDX);
   end

endmodule

// File: doc/stream_master_gen.md
# stream_master_gen

Parametrised valid/ready stream source, successor to the fixed 32-bit counter master used in the handshake test benches. It emits an incrementing data sequence under full valid/ready rules: data held stable while stalled, advance only on handshake. It supports continuous, gapped and packetised modes with a `last` marker. It sits upstream of any slave under test and drives the same data/valid/ready interface.

## Interface
- `DATA_W`, 32, data width (≥ 8).
- `PKT_LEN`, 16, beats per packet in packet mode (≥ 1).
- `GAP_CYC`, 0, idle cycles inserted by gapped/packet modes (0 = none).
- `START_VAL`, 0, first data value after reset.

- `clk` input 1: clock, single domain.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: generation enable.
- `mode` input 2: 0 continuous, 1 gapped (gap after every beat), 2 packet (gap after each `last` beat), 3 reserved (treated as 0).
- `ready` input 1: downstream ready.
- `data` output DATA_W: current beat value.
- `valid` output 1: beat available.
- `last` output 1: final beat of packet (mode 2 only, else 0).
- `pkt_cnt` output 16: completed packets, wraps 0xFFFF→0.

## Operation
- All outputs registered. Reset values: `data`=START_VAL, `valid`=0, `last`=0, `pkt_cnt`=0, state IDLE, beat index 0, gap counter 0.
- Handshake = `valid && ready` at a rising edge.
- States: IDLE, SEND, GAP.
  - IDLE: `valid`=0. `en`=1 → SEND, latch `mode`.
  - SEND: `valid`=1. On handshake: `data`←`data`+1 (mod 2^DATA_W, FFFF_FFFF→0 at 32 bits); beat index +1. Then:
    - mode 0, or gap not required: stay SEND.
    - mode 1 with GAP_CYC>0, or mode 2 on a `last` beat with GAP_CYC>0: → GAP.
    - `en`=0 at handshake: → IDLE (overrides GAP).
  - GAP: `valid`=0; count GAP_CYC cycles, then → SEND (relatch `mode`), or → IDLE if `en`=0.
- No handshake in SEND: `data`, `valid`, `last` held unchanged regardless of `en` or `mode`. `valid` is never withdrawn before handshake.
- `last` = 1 while beat index = PKT_LEN-1 in mode 2. Beat index resets to 0 after the `last` handshake. `pkt_cnt` increments on the same edge. With PKT_LEN=1 every beat is `last`.
- `mode` is sampled only on entry to SEND. Changes mid-packet or mid-stall are ignored until then.
- Beat index is not cleared on IDLE. A packet interrupted by `en`=0 resumes at its index.
- Async `rst` mid-beat clears everything immediately. The first beat after release is START_VAL.

## Timing
- `en` rising at edge N → `valid`=1 after edge N+1. First `data` = START_VAL.
- Mode 0 with `ready` held 1: one beat per cycle, zero bubbles.
- Mode 1: beat, then exactly GAP_CYC cycles `valid`=0, repeating. Period GAP_CYC+1 with `ready`=1.
- Mode 2: PKT_LEN back-to-back beats, then GAP_CYC idle cycles.
- `ready` is used combinationally only for next-state logic. No combinational path from `ready` to any output.

## Structure
- Shared package `stream_gen_pkg`:
  - mode encodings `MODE_CONT`, `MODE_GAP`, `MODE_PKT`;
  - state enum `ST_IDLE`, `ST_SEND`, `ST_GAP`;
  - `PKT_CNT_W`=16.
- Single module. The gap counter and beat index are inline counters sized with $clog2(GAP_CYC+1) and $clog2(PKT_LEN+1). No sub-module is warranted.

## Test plan
- Reset, then `en`=1, mode 0, `ready`=1 for 10 cycles → `data` 0..9 on consecutive cycles, `valid` continuously 1, `last`=0.
- Mode 0, `ready` low for 3 cycles while `data`=5 → `data`=5 and `valid`=1 held all 3 cycles. Next handshake then shows 6.
- Mode 1, GAP_CYC=2, `ready`=1 → pattern valid,0,0,valid…; values 0,1,2 on the valid cycles.
- Mode 2, PKT_LEN=4, GAP_CYC=1 → `last` on values 3 and 7; one idle cycle after each; `pkt_cnt` 1 then 2.
- DATA_W=8, START_VAL=8'hFE, mode 0 → sequence FE, FF, 00, 01.
- `rst` pulsed while stalled at `data`=7 → outputs immediately 0/0/START_VAL. After release with `en`=1, the first beat is START_VAL.
